// File: rtl/ua_receive_if.sv
// rtl/ua_receive_if.sv - byte output channel of the UART receiver
//
// Carries the received byte on a ready/valid handshake plus the two error pulses.
//   data          received byte, stable while valid=1
//   valid         byte available in the holding register
//   ready         consumer accepts the byte when valid && ready at a rising edge
//   framing_error one-cycle pulse: stop bit sampled low, byte dropped
//   overrun       one-cycle pulse: byte completed while the holding register was full
// master = receiver side, slave = consumer side.
interface ua_receive_if;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       framing_error;
   logic       overrun;

   modport master (output data, output valid, output framing_error, output overrun,
                   input ready);
   modport slave  (input data, input valid, input framing_error, input overrun,
                   output ready);
endinterface

// File: rtl/ua_receive.sv
// rtl/ua_receive.sv - 8N1 UART receiver with ready/valid byte output
//
// Recovers 1 start, 8 data (LSB first), 1 stop frames from an asynchronous serial
// line and holds each byte until the consumer takes it.
//   clk_i   system clock, all state on the rising edge
//   rst_ni  asynchronous active-low reset
//   sin_i   serial input, idle high, asynchronous to clk_i
//   rx_o    byte channel and error pulses (ua_receive_if master)
module ua_receive #(
   parameter int unsigned CLOCK_FREQ = 100_000_000,
   parameter int unsigned BAUD_RATE  = 115_200
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         sin_i,
   ua_receive_if.master rx_o
);
   localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
   localparam int unsigned CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
   localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

   logic             sync1_q, sync2_q, prev_q;
   logic [1:0]       fill_q;
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic [7:0]       data_q;
   logic             valid_q, ferr_q, ovr_q;

   logic             fall_d, byte_done_d;

   // Two-flop synchronizer. fill_q marks when sync2_q holds a sample taken after
   // reset release; prev_q is only allowed to read high from such a sample, so a
   // line held low through reset never looks like a start edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         fill_q  <= 2'b00;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sin_i;
         sync2_q <= sync1_q;
         fill_q  <= {fill_q[0], 1'b1};
         prev_q  <= sync2_q & fill_q[1];
      end
   end

   assign fall_d      = prev_q & ~sync2_q;
   assign byte_done_d = (state_q == ST_STOP) && (cnt_q == SYMBOL_LAST) && sync2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fall_d) begin
                  state_q <= ST_START;
                  cnt_q   <= '0;
               end
            end
            ST_START: begin
               if (cnt_q == SAMPLE_LAST) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  // a high line at mid start bit was a glitch: drop silently
                  state_q   <= sync2_q ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt_q == SYMBOL_LAST) begin
                  cnt_q              <= '0;
                  shift_q[bit_idx_q] <= sync2_q;
                  bit_idx_q          <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= ST_STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_STOP: begin
               if (cnt_q == SYMBOL_LAST) begin
                  // back to idle mid stop bit so a following start edge is not missed
                  cnt_q   <= '0;
                  state_q <= ST_IDLE;
                  ferr_q  <= ~sync2_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         // Holding register: a completing byte may replace one being accepted in
         // the same cycle; otherwise a full register keeps the old byte.
         if (byte_done_d) begin
            if (!valid_q || rx_o.ready) begin
               data_q  <= shift_q;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && rx_o.ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_o.data          = data_q;
   assign rx_o.valid         = valid_q;
   assign rx_o.framing_error = ferr_q;
   assign rx_o.overrun       = ovr_q;
endmodule

// File: tb/tb_ua_receive.sv
// tb/tb_ua_receive.sv - self-checking bench for ua_receive
module tb_ua_receive;
   localparam int CF   = 1_600_000;
   localparam int BR   = 100_000;
   localparam int T    = CF / BR;
   localparam int H    = T / 2;
   localparam int LAT  = 2;
   localparam int NMAX = 30000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sin = 1'b1;

   ua_receive_if rx ();

   ua_receive #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .sin_i (sin),
      .rx_o  (rx)
   );

   always #5 clk = ~clk;

   bit         srow [NMAX];
   bit         rstl [NMAX];
   bit         rdy  [NMAX];
   int         rel_at [NMAX];
   int         evk  [NMAX];
   logic [7:0] evb  [NMAX];
   logic [7:0] x_data [NMAX];
   bit         x_valid [NMAX];
   bit         x_ferr [NMAX];
   bit         x_ovr [NMAX];

   int wp = 0;
   int rmode = 1;
   int errors = 0;
   int checks = 0;

   task automatic put(input bit s, input int n);
      for (int i = 0; i < n; i++) begin
         if (wp < NMAX) begin
            srow[wp] = s;
            rstl[wp] = 1'b0;
            rdy[wp]  = (rmode == 2) ? bit'($urandom_range(0, 1)) : (rmode == 1);
            wp++;
         end
      end
   endtask

   task automatic put_rst(input int n, input bit s);
      for (int i = 0; i < n; i++) begin
         if (wp < NMAX) begin
            srow[wp] = s;
            rstl[wp] = 1'b1;
            rdy[wp]  = 1'b0;
            wp++;
         end
      end
   endtask

   task automatic frame(input logic [7:0] b, input bit stop, input int len, output int k);
      k = wp;
      for (int c = 0; c < len && c < 10 * T; c++) begin
         int sym;
         bit lv;
         sym = c / T;
         if (sym == 0)      lv = 1'b0;
         else if (sym <= 8) lv = b[sym-1];
         else               lv = stop;
         put(lv, 1);
      end
   endtask

   // Reference: scan the line for falling edges the receiver may see, then read the
   // start, data and stop levels at the fixed sample offsets from each edge.
   task automatic build_model();
      int         rel;
      int         free_at;
      int         p;
      logic [7:0] b;
      logic [7:0] d;
      bit         v;
      rel = 0;
      free_at = 0;
      for (int n = 0; n < wp; n++) begin
         if (rstl[n]) rel = n + 1;
         rel_at[n] = rel;
      end
      for (int e = 3; e < wp; e++) begin
         if (e < free_at || rstl[e] || (e - 3) < rel_at[e]) continue;
         if (!(srow[e-3] && !srow[e-2])) continue;
         p = srow[e+H-2] ? e + H : e + H + 9 * T;
         if (p >= wp) break;
         if (rel_at[p] > e) begin
            free_at = e + 1;
            continue;
         end
         free_at = p + 1;
         if (p == e + H) continue;
         for (int i = 0; i < 8; i++) b[i] = srow[e + H + (i + 1) * T - 2];
         if (srow[p-2]) begin
            evk[p] = 1;
            evb[p] = b;
         end else begin
            evk[p] = 2;
         end
      end
      d = 8'h00;
      v = 1'b0;
      for (int n = 0; n < wp; n++) begin
         x_ferr[n] = 1'b0;
         x_ovr[n]  = 1'b0;
         if (rstl[n]) begin
            d = 8'h00;
            v = 1'b0;
         end else begin
            x_ferr[n] = (evk[n] == 2);
            if (evk[n] == 1) begin
               if (!v || rdy[n]) begin
                  d = evb[n];
                  v = 1'b1;
               end else begin
                  x_ovr[n] = 1'b1;
               end
            end else if (v && rdy[n]) begin
               v = 1'b0;
            end
         end
         x_data[n]  = d;
         x_valid[n] = v;
      end
   endtask

   function automatic int count_ev(input int a, input int b, input int kind);
      int c;
      c = 0;
      for (int n = a; n < b && n < NMAX; n++) if (evk[n] == kind) c++;
      return c;
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   int k_a5, k_gl, k_3c, k_11, k_22, k_ff, k_5a, k_lo, k_77, k_tmp;
   int done_off;

   initial begin
      done_off = LAT + H + 9 * T;

      // reset with toggling line, then 20 bit times idle
      for (int i = 0; i < 7; i++) put_rst(1, bit'($urandom_range(0, 1)));
      put_rst(3, 1'b1);
      rmode = 1;
      put(1'b1, 20 * T);
      frame(8'hA5, 1'b1, 10 * T, k_a5);
      put(1'b1, 2 * T);
      k_gl = wp;
      put(1'b0, H / 2);
      put(1'b1, 3 * T);
      frame(8'h3C, 1'b0, 10 * T, k_3c);
      put(1'b1, 2 * T);
      rmode = 0;
      frame(8'h11, 1'b1, 10 * T, k_11);
      frame(8'h22, 1'b1, 10 * T, k_22);
      put(1'b1, T);
      rmode = 1;
      put(1'b1, 3 * T);
      frame(8'hFF, 1'b1, 5 * T + H, k_ff);
      put_rst(4, 1'b1);
      put(1'b1, 3 * T);
      frame(8'h5A, 1'b1, 10 * T, k_5a);
      put(1'b1, 2 * T);
      k_lo = wp;
      put_rst(3, 1'b0);
      put(1'b0, 3 * T);
      put(1'b1, 2 * T);
      frame(8'h77, 1'b1, 10 * T, k_77);
      put(1'b1, 2 * T);

      while (wp < NMAX - 14 * T) begin
         int kind;
         rmode = $urandom_range(0, 2);
         kind  = $urandom_range(0, 9);
         case (kind)
            0: begin
               put(1'b0, $urandom_range(1, H - 2));
               put(1'b1, $urandom_range(3, T));
            end
            1: begin
               frame(8'($urandom), 1'b0, 10 * T, k_tmp);
               put(1'b1, $urandom_range(1, 2 * T));
            end
            2: begin
               frame(8'($urandom), 1'b1, $urandom_range(1, 10 * T - 1), k_tmp);
               put_rst($urandom_range(1, 4), 1'b1);
               put(1'b1, $urandom_range(3, 2 * T));
            end
            default: begin
               frame(8'($urandom), 1'b1, 10 * T, k_tmp);
               put(1'b1, $urandom_range(0, 2 * T));
            end
         endcase
      end
      rmode = 1;
      put(1'b1, 12 * T);

      build_model();

      // hand-derived expectations pinning the model
      chk("idle_after_reset_no_bytes", count_ev(0, k_a5, 1) + count_ev(0, k_a5, 2), 0);
      chk("a5_done_kind", evk[k_a5 + done_off], 1);
      chk("a5_byte", int'(evb[k_a5 + done_off]), 'hA5);
      chk("a5_valid_one_cycle", int'(x_valid[k_a5 + done_off]) + int'(x_valid[k_a5 + done_off + 1]), 1);
      chk("glitch_no_event", count_ev(k_gl, k_3c, 1) + count_ev(k_gl, k_3c, 2), 0);
      chk("3c_framing", evk[k_3c + done_off], 2);
      chk("3c_no_valid", int'(x_valid[k_3c + done_off]), 0);
      chk("11_byte", int'(evb[k_11 + done_off]), 'h11);
      chk("22_overrun", int'(x_ovr[k_22 + done_off]), 1);
      chk("22_keeps_11", int'(x_data[k_22 + done_off]), 'h11);
      chk("ff_dropped", count_ev(k_ff, k_5a, 1), 0);
      chk("5a_byte", int'(evb[k_5a + done_off]), 'h5A);
      chk("low_through_reset_silent", count_ev(k_lo, k_77, 1) + count_ev(k_lo, k_77, 2), 0);
      chk("77_byte", int'(evb[k_77 + done_off]), 'h77);

      rst_n    = !rstl[0];
      sin      = srow[0];
      rx.ready = rdy[0];
      fork
         begin
            for (int n = 1; n < wp; n++) begin
               @(negedge clk);
               rst_n    = !rstl[n];
               sin      = srow[n];
               rx.ready = rdy[n];
            end
         end
         begin
            for (int n = 0; n < wp && errors < 40; n++) begin
               @(posedge clk);
               #1;
               checks++;
               if (rx.valid !== x_valid[n] || rx.data !== x_data[n] ||
                   rx.framing_error !== x_ferr[n] || rx.overrun !== x_ovr[n]) begin
                  errors++;
                  $display("FAIL outputs cycle %0d: got valid=%b data=%h ferr=%b ovr=%b, want valid=%b data=%h ferr=%b ovr=%b",
                           n, rx.valid, rx.data, rx.framing_error, rx.overrun,
                           x_valid[n], x_data[n], x_ferr[n], x_ovr[n]);
               end
            end
         end
      join
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
